ps2_key_fifo: RTL and testbench

PS/2 keyboard receiver with glitch-filtered clock sampling, frame and parity checking, E0/F0 prefix decoding and a parametrised first-word-fall-through key-event FIFO. It sits between the top-level PS/2 pins and the game/display logic. It replaces the single-register keyboard path with a buffered, error-reporting event stream. Consumers read one decoded key event per `rd_en` pulse.

---
 rtl/ps2_key_fifo.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_key_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
//   PS/2 keyboard receiver. It synchronises both pins, glitch-filters the PS/2
//   clock, checks each 11-bit frame (start, 8 data bits LSB first, odd parity,
//   stop), folds the E0/F0 prefixes into flags, and queues decoded key events
//   in a first-word-fall-through FIFO.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   ps2_clk, ps2_data     raw asynchronous PS/2 pins
//   rd_en                 pop the head entry (ignored while key_valid=0)
//   clear_err             clear the sticky overflow/frame_err flags
//   key_valid             FIFO not empty; the head fields are valid
//   key_code/_break/_ext  head scan code, release flag, extended flag
//   fifo_count            number of entries held
//   overflow              sticky: an event was dropped on a full FIFO
//   frame_err             sticky: a frame had a bad parity or stop bit
//
// Handshake: a head entry is offered while key_valid=1. rd_en acts as ready,
// and an entry is consumed on each edge where key_valid and rd_en are both 1.
module ps2_key_fifo #(
    parameter int DEPTH          = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     rd_en,
    input  logic                     clear_err,
    output logic                     key_valid,
    output logic [7:0]               key_code,
    output logic                     key_break,
    output logic                     key_ext,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_err
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int FCW = $clog2(FILTER_LEN);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // ---------------- synchronisers and clock filter ----------------
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           sample;

    // The filter counts consecutive samples that disagree with its output and
    // flips once FILTER_LEN of them have been seen in a row.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        sample = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                sample = filt_q;  // only the 1->0 transition strobes
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // ---------------- frame FSM ----------------
    logic [1:0]     state_q, state_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TOW-1:0] to_q, to_d;
    logic           frame_good, frame_bad;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_d       = '0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (state_q != S_IDLE && !sample) to_d = to_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (sample && !dat_s2_q) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
            end
            default: begin
                if (sample) begin
                    state_d = S_IDLE;
                    if ((^{shift_q, par_q}) && dat_s2_q) frame_good = 1'b1;
                    else                                 frame_bad  = 1'b1;
                end
            end
        endcase
        // A stalled frame is dropped silently; no error is flagged.
        if (state_q != S_IDLE && !sample && to_q == TOW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            to_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            to_q    <= to_d;
        end
    end

    // ---------------- prefix decoder ----------------
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       push_q, push_d;
    logic [9:0] pdata_q, pdata_d;
    logic       frame_err_q, frame_err_d;

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        pdata_d     = pdata_q;
        frame_err_d = frame_bad | (frame_err_q & ~clear_err);
        if (frame_good) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push_d  = 1'b1;
                pdata_d = {ext_q, brk_q, shift_q};
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end
        end
        if (frame_bad) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    // ---------------- FIFO ----------------
    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, do_push;

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = rd_en && (count_q != '0);
    // A pop on the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push_q && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !pop)      count_d = count_q + 1'b1;
        else if (!do_push && pop) count_d = count_q - 1'b1;
        overflow_d = (push_q && full && !pop) | (overflow_q & ~clear_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            pdata_q     <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            pdata_q     <= pdata_d;
            frame_err_q <= frame_err_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= pdata_q;
    end

    // Head fields are forced to 0 when empty so stale storage never shows.
    assign key_valid  = (count_q != '0);
    assign key_ext    = key_valid & mem[rd_ptr_q][9];
    assign key_break  = key_valid & mem[rd_ptr_q][8];
    assign key_code   = key_valid ? mem[rd_ptr_q][7:0] : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;
  localparam int DEPTH   = 4;
  localparam int FLEN    = 4;
  localparam int TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, clear_err = 1'b0;
  logic key_valid, key_break, key_ext, overflow, frame_err;
  logic [7:0] key_code;
  logic [$clog2(DEPTH):0] fifo_count;

  ps2_key_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .clear_err(clear_err), .key_valid(key_valid),
    .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set while clock high, then a 20-cycle low phase.
  // With pop_at_push the bench raises rd_en for exactly the cycle the decoded
  // event is written: falling pin at E0, sample edge E0+2+FLEN, write edge +1.
  task automatic send_bit(input logic b, input logic pop_at_push);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    if (pop_at_push) begin
      tick(2 + FLEN);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(20 - 3 - FLEN);
    end else begin
      tick(20);
    end
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_at_push);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(~(^b) ^ bad_par, 1'b0);
    send_bit(1'b1, pop_at_push);
    tick(10);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, {24'h0, key_code}, {24'h0, e});
    pop_one();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    check("reset_valid", {31'h0, key_valid}, 32'h0);
    check("reset_code", {24'h0, key_code}, 32'h0);
    check("reset_count", 32'(fifo_count), 32'h0);
    check("reset_ovf", {31'h0, overflow}, 32'h0);
    check("reset_ferr", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    tick(5);

    // make code
    send_frame(8'h1C, 1'b0, 1'b0);
    check("make_valid", {31'h0, key_valid}, 32'h1);
    check("make_code", {24'h0, key_code}, 32'h1C);
    check("make_brk", {31'h0, key_break}, 32'h0);
    check("make_ext", {31'h0, key_ext}, 32'h0);
    check("make_count", 32'(fifo_count), 32'h1);
    pop_one();
    check("pop_valid", {31'h0, key_valid}, 32'h0);
    check("pop_count", 32'(fifo_count), 32'h0);
    pop_one();
    check("pop_empty_count", 32'(fifo_count), 32'h0);

    // extended release
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("prefix_no_push", 32'(fifo_count), 32'h0);
    send_frame(8'h74, 1'b0, 1'b0);
    check("ext_count", 32'(fifo_count), 32'h1);
    check("ext_code", {24'h0, key_code}, 32'h74);
    check("ext_ext", {31'h0, key_ext}, 32'h1);
    check("ext_brk", {31'h0, key_break}, 32'h1);
    pop_one();

    // parity error
    send_frame(8'h1C, 1'b1, 1'b0);
    check("par_count", 32'(fifo_count), 32'h0);
    check("par_ferr", {31'h0, frame_err}, 32'h1);
    send_frame(8'h32, 1'b0, 1'b0);
    check("par_next_code", {24'h0, key_code}, 32'h32);
    check("par_next_flags", {30'h0, key_ext, key_break}, 32'h0);
    check("par_ferr_sticky", {31'h0, frame_err}, 32'h1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("par_ferr_clear", {31'h0, frame_err}, 32'h0);
    pop_one();

    // overflow
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      if (i <= DEPTH) exp_q.push_back(8'(i));
    end
    check("ovf_count", 32'(fifo_count), 32'h4);
    check("ovf_flag", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_order");
    check("ovf_drained", {31'h0, key_valid}, 32'h0);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("ovf_clear", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h0A + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'h0A + 8'(i));
    end
    check("full_count", 32'(fifo_count), 32'h4);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h0E);
    send_frame(8'h0E, 1'b0, 1'b1);
    check("fullpop_count", 32'(fifo_count), 32'h4);
    check("fullpop_ovf", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < DEPTH; i++) pop_check("fullpop_order");

    // timeout: start + 4 data bits, then the clock stalls
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    tick(TIMEOUT + 40);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("to_count", 32'(fifo_count), 32'h1);
    check("to_code", {24'h0, key_code}, 32'h1C);
    check("to_ferr", {31'h0, frame_err}, 32'h0);
    pop_one();

    // 1-cycle glitch with data low would look like a start bit if sampled
    ps2_data = 1'b0;
    tick(3);
    ps2_clk = 1'b0;
    tick(1);
    ps2_clk = 1'b1;
    tick(20);
    ps2_data = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    check("glitch_count", 32'(fifo_count), 32'h1);
    check("glitch_code", {24'h0, key_code}, 32'h5A);
    check("glitch_ferr", {31'h0, frame_err}, 32'h0);
    pop_one();

    // reset mid-frame with 2 entries queued
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    check("pre_rst_count", 32'(fifo_count), 32'h2);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_valid", {31'h0, key_valid}, 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_code", {24'h0, key_code}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("post_rst_count", 32'(fifo_count), 32'h1);
    check("post_rst_code", {24'h0, key_code}, 32'h1C);
    check("post_rst_flags", {30'h0, key_ext, key_break}, 32'h0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
